// File: rtl/rewind_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rewind_fifo
// Purpose  : Parametrised synchronous FIFO with flush, read-pointer
//            mark/rewind, occupancy counts, almost-full/almost-empty
//            thresholds and sticky overflow/underflow flags. Entries popped
//            after a mark stay write-protected until release, so a rewind
//            always replays intact data.
// Ports    : clk, rst_n (async, active-low)
//            i_flush, i_mark, i_rewind, i_release  - control
//            i_push/i_rear                          - write side
//            i_pop -> o_front/o_vld (1-cycle latency) - read side
//            o_empty, o_full, o_afull, o_aempty     - status
//            o_count, o_used, o_mark_vld            - occupancy / mark
//            o_ovf, o_udf                           - sticky errors
//            o_rptr, o_wptr                         - debug pointers
// Revision : 1.0 - initial release
// ============================================================================
module rewind_fifo #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  parameter int ADDR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_mark,
  input  logic              i_rewind,
  input  logic              i_release,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_rear,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_front,
  output logic              o_vld,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_afull,
  output logic              o_aempty,
  output logic [ADDR_W:0]   o_count,
  output logic [ADDR_W:0]   o_used,
  output logic              o_mark_vld,
  output logic              o_ovf,
  output logic              o_udf,
  output logic [ADDR_W:0]   o_rptr,
  output logic [ADDR_W:0]   o_wptr
);

  localparam int              c_PW     = ADDR_W + 1;
  localparam logic [ADDR_W:0] c_DEPTH  = c_PW'(DEPTH);
  localparam logic [ADDR_W:0] c_AFULL  = c_PW'(AFULL_TH);
  localparam logic [ADDR_W:0] c_AEMPTY = c_PW'(AEMPTY_TH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W:0]   wptr_q, wptr_d;
  logic [ADDR_W:0]   rptr_q, rptr_d;
  logic [ADDR_W:0]   mptr_q, mptr_d;
  logic              mark_vld_q, mark_vld_d;
  logic              vld_q, vld_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic [DATA_W-1:0] front_q, front_d;

  logic [ADDR_W:0]   w_count;
  logic [ADDR_W:0]   w_used;
  logic              w_full;
  logic              w_empty;
  logic              w_push_ok;
  logic              w_pop_ok;

  // Pointers carry one extra wrap bit, so the differences are exact
  // occupancies in 0..DEPTH.
  assign w_count = wptr_q - rptr_q;
  assign w_used  = mark_vld_q ? (wptr_q - mptr_q) : w_count;
  assign w_full  = (w_used == c_DEPTH);
  assign w_empty = (w_count == '0);

  // Fullness is judged on used, not count, which is what protects the
  // marked window from being overwritten.
  assign w_push_ok = i_push && !w_full && !i_flush;
  assign w_pop_ok  = i_pop && !w_empty && !i_rewind && !i_flush;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    mptr_d     = mptr_q;
    mark_vld_d = mark_vld_q;
    vld_d      = 1'b0;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    front_d    = front_q;

    if (i_flush) begin
      wptr_d     = '0;
      rptr_d     = '0;
      mptr_d     = '0;
      mark_vld_d = 1'b0;
      ovf_d      = 1'b0;
      udf_d      = 1'b0;
    end else begin
      if (w_push_ok) begin
        wptr_d = wptr_q + 1'b1;
      end
      if (i_push && w_full) begin
        ovf_d = 1'b1;
      end

      // A pop coinciding with a rewind is dropped silently, never an underflow.
      if (i_pop && w_empty && !i_rewind) begin
        udf_d = 1'b1;
      end
      if (w_pop_ok) begin
        rptr_d  = rptr_q + 1'b1;
        vld_d   = 1'b1;
        front_d = mem_q[rptr_q[ADDR_W-1:0]];
      end

      // Control priority: rewind > mark > release. The mark captures the
      // read pointer before any same-cycle pop increment.
      if (i_rewind) begin
        if (mark_vld_q) begin
          rptr_d = mptr_q;
        end
      end else if (i_mark) begin
        mptr_d     = rptr_q;
        mark_vld_d = 1'b1;
      end else if (i_release) begin
        mark_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      mptr_q     <= '0;
      mark_vld_q <= 1'b0;
      vld_q      <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      front_q    <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      mptr_q     <= mptr_d;
      mark_vld_q <= mark_vld_d;
      vld_q      <= vld_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      front_q    <= front_d;
    end
  end

  // Storage array is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      mem_q[wptr_q[ADDR_W-1:0]] <= i_rear;
    end
  end

  assign o_front    = front_q;
  assign o_vld      = vld_q;
  assign o_empty    = w_empty;
  assign o_full     = w_full;
  assign o_afull    = (w_used >= c_AFULL);
  assign o_aempty   = (w_count <= c_AEMPTY);
  assign o_count    = w_count;
  assign o_used     = w_used;
  assign o_mark_vld = mark_vld_q;
  assign o_ovf      = ovf_q;
  assign o_udf      = udf_q;
  assign o_rptr     = rptr_q;
  assign o_wptr     = wptr_q;

endmodule
`default_nettype wire

// File: tb/tb_rewind_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_rewind_fifo
// Purpose  : Self-checking bench for rewind_fifo. A queue-based model keeps
//            the readable entries and the protected (popped-since-mark)
//            entries as separate queues; a rewind splices them back together.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rewind_fifo;

  localparam int DW   = 16;
  localparam int DEP  = 16;
  localparam int AW   = 4;
  localparam int PW   = AW + 1;
  localparam int AFT  = DEP - 2;
  localparam int AET  = 2;
  localparam int SW   = DW + 5 + 4 * PW + 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_flush = 1'b0, i_mark = 1'b0, i_rewind = 1'b0, i_release = 1'b0;
  logic          i_push = 1'b0, i_pop = 1'b0;
  logic [DW-1:0] i_rear = '0;
  logic [DW-1:0] o_front;
  logic          o_vld, o_empty, o_full, o_afull, o_aempty;
  logic [AW:0]   o_count, o_used, o_rptr, o_wptr;
  logic          o_mark_vld, o_ovf, o_udf;

  int checks   = 0;
  int failures = 0;

  rewind_fifo #(.DATA_W(DW), .DEPTH(DEP), .AFULL_TH(AFT), .AEMPTY_TH(AET)) dut (
    .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_mark(i_mark),
    .i_rewind(i_rewind), .i_release(i_release), .i_push(i_push),
    .i_rear(i_rear), .i_pop(i_pop), .o_front(o_front), .o_vld(o_vld),
    .o_empty(o_empty), .o_full(o_full), .o_afull(o_afull),
    .o_aempty(o_aempty), .o_count(o_count), .o_used(o_used),
    .o_mark_vld(o_mark_vld), .o_ovf(o_ovf), .o_udf(o_udf),
    .o_rptr(o_rptr), .o_wptr(o_wptr)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [DW-1:0] m_q[$];   // readable entries, oldest first
  logic [DW-1:0] m_h[$];   // entries popped since the mark
  logic          m_mark, m_vld, m_ovf, m_udf;
  logic [DW-1:0] m_front;
  int            m_rptr, m_wptr;

  logic [SW-1:0] dut_vec;
  assign dut_vec = {o_front, o_vld, o_empty, o_full, o_afull, o_aempty,
                    o_count, o_used, o_mark_vld, o_ovf, o_udf, o_rptr, o_wptr};

  function automatic logic [SW-1:0] exp_vec();
    int cnt  = m_q.size();
    int used = m_q.size() + m_h.size();
    logic e  = (cnt == 0);
    logic f  = (used == DEP);
    logic af = (used >= AFT);
    logic ae = (cnt <= AET);
    return {m_front, m_vld, e, f, af, ae, PW'(cnt), PW'(used),
            m_mark, m_ovf, m_udf, PW'(m_rptr), PW'(m_wptr)};
  endfunction

  task automatic model_reset();
    m_q.delete(); m_h.delete();
    m_mark = 0; m_vld = 0; m_ovf = 0; m_udf = 0; m_front = '0;
    m_rptr = 0; m_wptr = 0;
  endtask

  task automatic model_step(input logic push, input logic [DW-1:0] d,
                            input logic pop, input logic mk, input logic rw,
                            input logic rl, input logic fl);
    logic full  = ((m_q.size() + m_h.size()) == DEP);
    logic empty = (m_q.size() == 0);
    if (fl) begin
      m_q.delete(); m_h.delete();
      m_mark = 0; m_vld = 0; m_ovf = 0; m_udf = 0;
      m_rptr = 0; m_wptr = 0;
      return;
    end
    if (rw) begin
      if (m_mark) begin
        m_q    = {m_h, m_q};
        m_rptr = (m_rptr - m_h.size() + 2 * DEP) % (2 * DEP);
        m_h.delete();
      end
    end else if (mk) begin
      m_h.delete();
      m_mark = 1;
    end else if (rl) begin
      m_h.delete();
      m_mark = 0;
    end
    m_vld = 0;
    if (pop && !rw) begin
      if (empty) m_udf = 1;
      else begin
        m_front = m_q.pop_front();
        if (m_mark) m_h.push_back(m_front);
        m_vld  = 1;
        m_rptr = (m_rptr + 1) % (2 * DEP);
      end
    end
    if (push) begin
      if (full) m_ovf = 1;
      else begin
        m_q.push_back(d);
        m_wptr = (m_wptr + 1) % (2 * DEP);
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
  task automatic step(input logic push, input logic [DW-1:0] d, input logic pop,
                      input logic mk, input logic rw, input logic rl, input logic fl);
    i_push = push; i_rear = d; i_pop = pop; i_mark = mk;
    i_rewind = rw; i_release = rl; i_flush = fl;
    model_step(push, d, pop, mk, rw, rl, fl);
    @(posedge clk);
    #1;
    i_push = 0; i_pop = 0; i_mark = 0; i_rewind = 0; i_release = 0; i_flush = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_vec !== exp_vec()) begin
      failures++; $display("FAIL reset dut=%h exp=%h", dut_vec, exp_vec());
    end
    rst_n = 1;
    #1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEP; i++) begin
      step(1, DW'(i), 0, 0, 0, 0, 0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL fill_%0d dut=%h exp=%h", i, dut_vec, exp_vec());
      end
      checks++;
      if (o_afull !== (i + 1 >= AFT)) begin
        failures++; $display("FAIL fill_afull_%0d got=%b exp=%b", i, o_afull, (i + 1 >= AFT));
      end
    end
    checks++;
    if (o_full !== 1'b1) begin
      failures++; $display("FAIL fill_full got=%b exp=1", o_full);
    end
    step(1, 16'd16, 0, 0, 0, 0, 0);
    checks++;
    if (o_ovf !== 1'b1 || o_count !== 5'd16) begin
      failures++; $display("FAIL fill_ovf ovf=%b count=%0d exp ovf=1 count=16", o_ovf, o_count);
    end
  endtask

  task automatic test_stream();
    step(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(1, DW'(i), 0, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) begin
      step(0, 0, 1, 0, 0, 0, 0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL stream_%0d dut=%h exp=%h", i, dut_vec, exp_vec());
      end
      if (i < 10) begin
        checks++;
        if (o_vld !== 1'b1 || o_front !== DW'(i)) begin
          failures++; $display("FAIL stream_data_%0d vld=%b front=%0d exp vld=1 front=%0d", i, o_vld, o_front, i);
        end
      end
    end
    checks++;
    if (o_udf !== 1'b1 || o_vld !== 1'b0) begin
      failures++; $display("FAIL stream_udf udf=%b vld=%b exp udf=1 vld=0", o_udf, o_vld);
    end
  endtask

  task automatic test_rewind();
    step(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(1, DW'(i), 0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    repeat (4) step(0, 0, 1, 0, 0, 0, 0);
    checks++;
    if (o_used !== 5'd7 || o_count !== 5'd3) begin
      failures++; $display("FAIL rew_pre used=%0d count=%0d exp used=7 count=3", o_used, o_count);
    end
    step(0, 0, 0, 0, 1, 0, 0);
    checks++;
    if (o_used !== 5'd7 || o_rptr !== 5'd3 || o_mark_vld !== 1'b1) begin
      failures++; $display("FAIL rew_post used=%0d rptr=%0d mark=%b exp 7 3 1", o_used, o_rptr, o_mark_vld);
    end
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 0, 0, 0, 0);
      checks++;
      if (o_front !== DW'(3 + k) || dut_vec !== exp_vec()) begin
        failures++; $display("FAIL rew_data_%0d front=%0d exp=%0d dut=%h model=%h", k, o_front, 3 + k, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_mark_full();
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < DEP; i++) step(1, DW'(100 + i), 0, 0, 0, 0, 0);
    for (int i = 0; i < DEP; i++) step(0, 0, 1, 0, 0, 0, 0);
    checks++;
    if (o_full !== 1'b1 || o_empty !== 1'b1 || dut_vec !== exp_vec()) begin
      failures++; $display("FAIL mfull_held full=%b empty=%b exp 1 1 dut=%h model=%h", o_full, o_empty, dut_vec, exp_vec());
    end
    step(1, 16'hBEEF, 0, 0, 0, 0, 0);
    checks++;
    if (o_wptr !== 5'd16 || o_ovf !== 1'b1) begin
      failures++; $display("FAIL mfull_reject wptr=%0d ovf=%b exp 16 1", o_wptr, o_ovf);
    end
    step(0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (o_full !== 1'b0 || o_used !== 5'd0 || o_mark_vld !== 1'b0) begin
      failures++; $display("FAIL mfull_release full=%b used=%0d mark=%b exp 0 0 0", o_full, o_used, o_mark_vld);
    end
    step(1, 16'h1234, 0, 0, 0, 0, 0);
    checks++;
    if (o_count !== 5'd1 || dut_vec !== exp_vec()) begin
      failures++; $display("FAIL mfull_push count=%0d exp 1 dut=%h model=%h", o_count, dut_vec, exp_vec());
    end
  endtask

  task automatic test_same_cycle();
    step(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, DW'(50 + i), 0, 0, 0, 0, 0);
    repeat (2) step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1, 0, 0);   // rewind + pop
    checks++;
    if (o_rptr !== 5'd2 || o_vld !== 1'b0 || o_udf !== 1'b0) begin
      failures++; $display("FAIL sc_rew_pop rptr=%0d vld=%b udf=%b exp 2 0 0", o_rptr, o_vld, o_udf);
    end
    repeat (2) step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);   // mark + rewind: rewind only
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    checks++;
    if (o_rptr !== 5'd2 || dut_vec !== exp_vec()) begin
      failures++; $display("FAIL sc_mark_rew rptr=%0d exp 2 dut=%h model=%h", o_rptr, dut_vec, exp_vec());
    end
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 16'hA1, 0, 0, 0, 0, 0);
    step(1, 16'hA2, 1, 0, 0, 0, 0);  // push + pop on 1 entry
    checks++;
    if (o_count !== 5'd1 || o_front !== 16'hA1 || o_vld !== 1'b1) begin
      failures++; $display("FAIL sc_push_pop count=%0d front=%h vld=%b exp 1 a1 1", o_count, o_front, o_vld);
    end
  endtask

  task automatic test_flush_reset();
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i <= DEP; i++) step(1, DW'(200 + i), 0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 1, 0, 0, 0, 0);
    step(1, 16'h77, 1, 0, 0, 0, 1);  // flush wins over push and pop
    checks++;
    if (o_rptr !== 5'd0 || o_wptr !== 5'd0 || o_empty !== 1'b1 || o_mark_vld !== 1'b0 ||
        o_ovf !== 1'b0 || o_udf !== 1'b0 || o_vld !== 1'b0) begin
      failures++; $display("FAIL flush dut=%h exp=%h", dut_vec, exp_vec());
    end
    for (int i = 0; i < 5; i++) step(1, DW'(300 + i), i[0], 0, 0, 0, 0);
    i_push = 1; i_rear = 16'h55;
    #2;
    rst_n = 0;                       // mid-cycle, no clock edge involved
    model_reset();
    #1;
    checks++;
    if (dut_vec !== exp_vec()) begin
      failures++; $display("FAIL async_reset dut=%h exp=%h", dut_vec, exp_vec());
    end
    i_push = 0;
    @(posedge clk);
    #3;
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      logic ps  = ($urandom_range(99) < 55);
      logic pp  = ($urandom_range(99) < 50);
      logic mk  = ($urandom_range(99) < 5);
      logic rw  = ($urandom_range(99) < 5);
      logic rl  = ($urandom_range(99) < 4);
      logic fl  = ($urandom_range(199) == 0);
      step(ps, DW'($urandom), pp, mk, rw, rl, fl);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL random_%0d dut=%h exp=%h", n, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_fill();
    test_stream();
    test_rewind();
    test_mark_full();
    test_same_cycle();
    test_flush_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/rewind_fifo.md
Name: rewind_fifo

Overview:
Parametrised synchronous FIFO with flush, read-pointer mark/rewind, occupancy counts, almost-full/almost-empty thresholds and sticky overflow/underflow flags. It is the generalised successor of the fixed 16-bit sample FIFO. Used wherever a consumer must replay a stretch of data, e.g. re-reading a window after a failed decode. Marked data is write-protected until released, so a rewind always returns intact data.

Parameters:
DATA_W, 16, data width in bits
DEPTH, 16, entries; must be a power of 2, at least 4
AFULL_TH, DEPTH-2, o_afull asserts when used >= AFULL_TH
AEMPTY_TH, 2, o_aempty asserts when count <= AEMPTY_TH
ADDR_W, $clog2(DEPTH), derived; do not override

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
i_flush  in  1  empty FIFO, clear mark and error flags
i_mark  in  1  record current read pointer as rewind point
i_rewind  in  1  move read pointer back to the mark
i_release  in  1  drop the mark, freeing protected entries
i_push  in  1  write request
i_rear  in  DATA_W  write data
i_pop  in  1  read request
o_front  out  DATA_W  read data, registered
o_vld  out  1  o_front valid, 1-cycle pulse per accepted pop
o_empty  out  1  count == 0
o_full  out  1  used == DEPTH
o_afull  out  1  used >= AFULL_TH
o_aempty  out  1  count <= AEMPTY_TH
o_count  out  ADDR_W+1  readable entries (wptr - rptr)
o_used  out  ADDR_W+1  occupied entries including protected ones
o_mark_vld  out  1  a mark is held
o_ovf  out  1  sticky: a push was rejected
o_udf  out  1  sticky: a pop was rejected
o_rptr  out  ADDR_W+1  read pointer, debug
o_wptr  out  ADDR_W+1  write pointer, debug

Behaviour:
- Pointers: wptr, rptr and mptr are ADDR_W+1 bits and wrap modulo 2*DEPTH. The memory index is the low ADDR_W bits.
- count = wptr - rptr.
- used = mark_vld ? wptr - mptr : count.
- All status outputs decode combinationally from registered state, so they reflect state after the last edge.
- Reset (rst_n=0, async): pointers 0, mark_vld 0, o_front 0, o_vld 0, o_ovf 0, o_udf 0. Hence o_empty 1, o_full 0, o_aempty 1, o_afull 0. Memory contents are not reset.
- Push accepted iff i_push && !o_full. mem[wptr] <= i_rear, then wptr+1.
  - Rejected push sets o_ovf.
  - No full-bypass: a push while full is rejected even if a pop occurs in the same cycle.
- Pop accepted iff i_pop && !o_empty && !i_rewind. o_front <= mem[rptr], o_vld=1 on the next cycle, rptr+1.
  - Read latency is 1 cycle.
  - If there is no accepted pop, o_vld=0 and o_front holds its value.
  - Rejected pop (empty) sets o_udf.
- Simultaneous push and pop are both accepted when their conditions hold. No read/write address conflict is possible.
- Mark: mptr <= rptr, using the value before any same-cycle pop increment; mark_vld <= 1.
  - A new mark overwrites the old one.
  - After a mark, popped entries stay counted in used until release.
- Rewind: if mark_vld, rptr <= mptr and any same-cycle pop is ignored (not counted as underflow). The new rptr is visible next cycle.
  - The mark stays valid, so repeated rewinds are allowed.
  - Rewind with no mark is a no-op; the pop is still ignored.
- Release: mark_vld <= 0, so used reverts to count.
- Priority per cycle: flush > rewind > mark > release.
  - Rewind and mark together: rewind only.
  - Mark and release together: mark wins.
  - Push is independent of mark/rewind/release.
- Flush: wptr=rptr=mptr=0, mark_vld=0, o_vld=0, o_ovf=o_udf=0. Same-cycle push and pop are ignored.

Test Plan:
1. Reset, then push 0..15 on consecutive cycles (DEPTH=16) -> o_full=1 after 16th edge. Push 16 -> o_ovf=1 and o_count stays 16. o_afull=1 from used=14.
2. Push 0..9, then continuous pop -> o_front=0,1,... each one cycle after pop, o_vld high 10 cycles. Pop while empty -> o_udf=1 and o_vld=0.
3. Push 10 values (0..9), pop 3, mark (mptr=3), pop 4 more, rewind -> next pops return 3,4,5...; o_used=7 throughout rewind.
4. With mark at rptr=0 and 16 entries written, pop all 16 -> o_full stays 1, pushes rejected. Release -> o_full=0, o_used=0, next push accepted.
5. Same-cycle scenarios: rewind+pop leaves rptr=mptr with no o_vld; mark+rewind applies rewind only; push+pop on a 1-entry FIFO keeps count=1.
6. Mid-stream flush with mark held and o_ovf set -> all pointers 0, o_empty=1, o_mark_vld=0, errors cleared. Assert rst_n=0 mid-burst -> outputs return to reset values immediately without waiting for clk.
